// File: rtl/syscall_pkg.sv
`default_nettype none
// ============================================================================
//  Module : syscall_pkg
//  Purpose: Shared definitions for the syscall service blocks: syscall codes,
//           legal data-memory window, string length limit and the FSM state
//           encoding of the print_string reader.
//  Ports  : none (package)
//  Rev    : 1.0  initial release
// ============================================================================
package syscall_pkg;

    // Syscall codes carried in $v0
    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR = 32'd4;
    localparam logic [31:0] SYS_READ_INT  = 32'd5;
    localparam logic [31:0] SYS_EXIT      = 32'd10;

    // Inclusive window of word addresses the reader may fetch from
    localparam logic [31:0] MEM_LO = 32'h7FFF_FBFC;
    localparam logic [31:0] MEM_HI = 32'h7FFF_FFFC;

    // Character counter width and forced-abort length
    localparam int                CNT_W   = 9;
    localparam logic [CNT_W-1:0]  MAX_LEN = 9'd256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EMIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

endpackage : syscall_pkg
`default_nettype wire

// File: rtl/byte_lane_select.sv
`default_nettype none
// ============================================================================
//  Module : byte_lane_select
//  Purpose: Big-endian byte extraction from a 32-bit word.
//           lane 0 -> word[31:24] ... lane 3 -> word[7:0]
//  Ports  : word     in  32  source word
//           lane     in  2   byte lane index
//           byte_out out 8   selected byte
//  Rev    : 1.0  initial release
// ============================================================================
module byte_lane_select (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    output logic [7:0]  byte_out
);

    always_comb begin
        byte_out = word[31:24];
        case (lane)
            2'd0:    byte_out = word[31:24];
            2'd1:    byte_out = word[23:16];
            2'd2:    byte_out = word[15:8];
            default: byte_out = word[7:0];
        endcase
    end

endmodule : byte_lane_select
`default_nettype wire

// File: rtl/syscall_string_reader.sv
`default_nettype none
// ============================================================================
//  Module : syscall_string_reader
//  Purpose: print_string syscall engine. Reads a NUL-terminated string from
//           Data_Memory one word at a time and hands it to the console sink
//           one character per valid/ready handshake, stalling the CPU via busy.
//  Ports  : clk, reset (sync, active-high)
//           syscall_req, v0, a0          - request from decode / register file
//           busy, done, err              - status to the CPU
//           mem_read, mem_address,
//           mem_read_data                - Data_Memory async read port
//           char_valid, char_data,
//           char_ready                   - console sink handshake
//           char_count                   - characters emitted by this call
//  Rev    : 1.0  initial release
// ============================================================================
module syscall_string_reader
    import syscall_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             syscall_req,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_read,
    output logic [31:0]      mem_address,
    input  logic [31:0]      mem_read_data,
    output logic             char_valid,
    output logic [7:0]       char_data,
    input  logic             char_ready,
    output logic [CNT_W-1:0] char_count
);

    state_e             state_q, state_d;
    logic [31:0]        ptr_q, ptr_d;
    logic [31:0]        wbuf_q, wbuf_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Registered outputs, computed from next-state values
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mem_read_q, mem_read_d;
    logic [31:0]        mem_address_q, mem_address_d;
    logic               char_valid_q, char_valid_d;
    logic [7:0]         char_data_q, char_data_d;

    logic [31:0]        w_word_addr;
    logic               w_oob;
    logic               w_accept;
    logic [7:0]         w_next_byte;

    assign w_word_addr = {ptr_q[31:2], 2'b00};
    assign w_oob       = (w_word_addr < MEM_LO) || (w_word_addr > MEM_HI);
    assign w_accept    = char_valid_q && char_ready;

    // Byte that will be presented in the next cycle if we are in EMIT then
    byte_lane_select u_lane (
        .word     (wbuf_d),
        .lane     (ptr_d[1:0]),
        .byte_out (w_next_byte)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wbuf_d  = wbuf_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                if (syscall_req && (v0 == SYS_PRINT_STR)) begin
                    ptr_d   = a0;
                    count_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_oob) begin
                    state_d = ST_ERR;
                end else begin
                    wbuf_d  = mem_read_data;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // char_valid_q is low in EMIT only when the current lane is NUL
                if (!char_valid_q) begin
                    state_d = ST_DONE;
                end else if (w_accept) begin
                    ptr_d   = ptr_q + 32'd1;
                    count_d = count_q + 1'b1;
                    if (count_d == MAX_LEN) begin
                        state_d = ST_ERR;
                    end else if (ptr_d[1:0] == 2'b00) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        err_d         = (state_d == ST_ERR);
        mem_read_d    = (state_d == ST_FETCH);
        mem_address_d = mem_read_d ? {ptr_d[31:2], 2'b00} : mem_address_q;
        char_valid_d  = (state_d == ST_EMIT) && (w_next_byte != 8'h00);
        char_data_d   = char_valid_d ? w_next_byte : char_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            wbuf_q        <= '0;
            count_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            char_valid_q  <= 1'b0;
            char_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wbuf_q        <= wbuf_d;
            count_q       <= count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            char_valid_q  <= char_valid_d;
            char_data_q   <= char_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;
    assign char_valid  = char_valid_q;
    assign char_data   = char_data_q;
    assign char_count  = count_q;

endmodule : syscall_string_reader
`default_nettype wire

// File: tb/tb_syscall_string_reader.sv
`default_nettype none
// ============================================================================
//  Module : tb_syscall_string_reader
//  Purpose: Directed self-checking bench for syscall_string_reader with a
//           behavioural Data_Memory and a console sink monitor.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_syscall_string_reader;

    localparam logic [31:0] C_LO = 32'h7FFF_FBFC;
    localparam logic [31:0] C_HI = 32'h7FFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        syscall_req;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        busy, done, err, mem_read, char_valid, char_ready;
    logic [31:0] mem_address, mem_read_data;
    logic [7:0]  char_data;
    logic [8:0]  char_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [0:256];
    logic [31:0] off;
    logic [7:0]  chars [$];
    logic [31:0] fetch_addrs [$];

    always #5 clk = ~clk;

    syscall_string_reader dut (
        .clk           (clk),
        .reset         (reset),
        .syscall_req   (syscall_req),
        .v0            (v0),
        .a0            (a0),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .mem_read      (mem_read),
        .mem_address   (mem_address),
        .mem_read_data (mem_read_data),
        .char_valid    (char_valid),
        .char_data     (char_data),
        .char_ready    (char_ready),
        .char_count    (char_count)
    );

    // Behavioural Data_Memory async read port
    always_comb begin
        off           = mem_address - C_LO;
        mem_read_data = 32'hDEAD_BEEF;
        if ((mem_address >= C_LO) && (mem_address <= C_HI))
            mem_read_data = mem[off[10:2]];
    end

    // Sink / fetch monitor
    always @(posedge clk) begin
        if (!reset) begin
            if (char_valid && char_ready) chars.push_back(char_data);
            if (mem_read) fetch_addrs.push_back(mem_address);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i <= 256; i++) mem[i] = 32'h0;
    endtask

    task automatic clear_log();
        chars.delete();
        fetch_addrs.delete();
    endtask

    task automatic start_call(input logic [31:0] a, input logic [31:0] code);
        @(negedge clk);
        syscall_req = 1'b1;
        v0          = code;
        a0          = a;
        @(negedge clk);
        syscall_req = 1'b0;
    endtask

    task automatic wait_end(input string tag, output bit got_done, output bit got_err);
        bit timed_out;
        got_done  = 1'b0;
        got_err   = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (done || err) begin
                got_done  = done;
                got_err   = err;
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        bit timed_out;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (char_valid) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_valid_timeout"}, 64'(timed_out), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},   64'(busy),        64'd0);
        chk({tag, "_done"},   64'(done),        64'd0);
        chk({tag, "_err"},    64'(err),         64'd0);
        chk({tag, "_mrd"},    64'(mem_read),    64'd0);
        chk({tag, "_maddr"},  64'(mem_address), 64'd0);
        chk({tag, "_cvalid"}, 64'(char_valid),  64'd0);
        chk({tag, "_cdata"},  64'(char_data),   64'd0);
        chk({tag, "_ccount"}, 64'(char_count),  64'd0);
    endtask

    initial begin
        bit got_done, got_err, saw_activity;

        reset       = 1'b1;
        syscall_req = 1'b0;
        v0          = 32'd0;
        a0          = 32'd0;
        char_ready  = 1'b1;
        clear_mem();
        clear_log();

        // ---- reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        // ---- 1) "Hi\0" aligned
        mem[0] = 32'h4869_0000;
        clear_log();
        start_call(32'h7FFF_FBFC, 32'd4);
        chk("t1_busy_rise", 64'(busy), 64'd1);
        wait_end("t1", got_done, got_err);
        chk("t1_done",   64'(got_done),     64'd1);
        chk("t1_err",    64'(got_err),      64'd0);
        chk("t1_nchars", 64'(chars.size()), 64'd2);
        if (chars.size() == 2) begin
            chk("t1_c0", 64'(chars[0]), 64'h48);
            chk("t1_c1", 64'(chars[1]), 64'h69);
        end
        chk("t1_count", 64'(char_count), 64'd2);
        @(negedge clk);
        chk("t1_busy_low", 64'(busy), 64'd0);
        chk("t1_done_pulse", 64'(done), 64'd0);

        // ---- 2) unaligned start inside one word
        clear_mem();
        mem[1] = 32'h0041_4200;
        clear_log();
        start_call(32'h7FFF_FC01, 32'd4);
        wait_end("t2", got_done, got_err);
        chk("t2_done",    64'(got_done),           64'd1);
        chk("t2_nchars",  64'(chars.size()),       64'd2);
        if (chars.size() == 2) begin
            chk("t2_c0", 64'(chars[0]), 64'h41);
            chk("t2_c1", 64'(chars[1]), 64'h42);
        end
        chk("t2_fetches", 64'(fetch_addrs.size()), 64'd1);

        // ---- 3) word crossing "ABCDE\0"
        clear_mem();
        mem[1] = 32'h4142_4344;
        mem[2] = 32'h4500_0000;
        clear_log();
        start_call(32'h7FFF_FC00, 32'd4);
        wait_end("t3", got_done, got_err);
        chk("t3_done",    64'(got_done),           64'd1);
        chk("t3_nchars",  64'(chars.size()),       64'd5);
        chk("t3_fetches", 64'(fetch_addrs.size()), 64'd2);
        if (fetch_addrs.size() == 2)
            chk("t3_addr2", 64'(fetch_addrs[1]), 64'h7FFF_FC04);
        chk("t3_count",   64'(char_count), 64'd5);

        // ---- 4) backpressure on the second character
        clear_log();
        start_call(32'h7FFF_FC00, 32'd4);
        wait_valid("t4a");
        chk("t4_first", 64'(char_data), 64'h41);
        @(negedge clk);
        char_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(char_valid), 64'd1);
            chk("t4_hold_data",  64'(char_data),  64'h42);
        end
        char_ready = 1'b1;
        wait_end("t4", got_done, got_err);
        chk("t4_done",   64'(got_done),     64'd1);
        chk("t4_nchars", 64'(chars.size()), 64'd5);
        if (chars.size() == 5) begin
            chk("t4_c0", 64'(chars[0]), 64'h41);
            chk("t4_c1", 64'(chars[1]), 64'h42);
            chk("t4_c2", 64'(chars[2]), 64'h43);
            chk("t4_c3", 64'(chars[3]), 64'h44);
            chk("t4_c4", 64'(chars[4]), 64'h45);
        end

        // ---- 5a) out-of-range start address
        clear_log();
        start_call(32'h0000_1000, 32'd4);
        wait_end("t5a", got_done, got_err);
        chk("t5a_err",    64'(got_err),      64'd1);
        chk("t5a_done",   64'(got_done),     64'd0);
        chk("t5a_nchars", 64'(chars.size()), 64'd0);
        chk("t5a_count",  64'(char_count),   64'd0);

        // ---- 5b) over-long string aborts after 256 characters
        for (int i = 0; i < 80; i++) mem[i] = 32'h4142_4344;
        clear_log();
        start_call(C_LO, 32'd4);
        wait_end("t5b", got_done, got_err);
        chk("t5b_err",    64'(got_err),      64'd1);
        chk("t5b_nchars", 64'(chars.size()), 64'd256);
        chk("t5b_count",  64'(char_count),   64'd256);

        // ---- 5c) other syscall code is ignored
        clear_log();
        saw_activity = 1'b0;
        start_call(C_LO, 32'd1);
        repeat (10) begin
            @(negedge clk);
            if (busy || mem_read || char_valid || done || err) saw_activity = 1'b1;
        end
        chk("t5c_quiet",   64'(saw_activity),       64'd0);
        chk("t5c_fetches", 64'(fetch_addrs.size()), 64'd0);

        // ---- 6) reset mid-EMIT, then clean restart
        clear_mem();
        mem[1] = 32'h4142_4344;
        mem[2] = 32'h4500_0000;
        char_ready = 1'b0;
        start_call(32'h7FFF_FC00, 32'd4);
        wait_valid("t6a");
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("t6_rst");
        reset      = 1'b0;
        char_ready = 1'b1;
        clear_log();
        start_call(32'h7FFF_FC00, 32'd4);
        wait_end("t6", got_done, got_err);
        chk("t6_done",   64'(got_done),     64'd1);
        chk("t6_nchars", 64'(chars.size()), 64'd5);
        if (chars.size() == 5) begin
            chk("t6_c0", 64'(chars[0]), 64'h41);
            chk("t6_c4", 64'(chars[4]), 64'h45);
        end
        chk("t6_count", 64'(char_count), 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_syscall_string_reader
`default_nettype wire
